burst_main_memory: RTL and testbench

Parametrised successor to the single-word main memory. A word-addressed RAM with programmable access latency, line (burst) transfers for cache refill and writeback, and a proper valid/ready request handshake with explicit completion signalling. Sits behind the data/instruction caches and serves one line request at a time.

---
 rtl/burst_main_memory_if.sv | 32 +++
 rtl/burst_main_memory.sv | 148 ++++++++++++++
 tb/tb_burst_main_memory.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/burst_main_memory_if.sv
// Request/response bundle between a cache (master) and burst_main_memory (slave).
// Handshake: a request transfers on a rising edge where req_valid & req_ready are both high.
// The master holds req_valid and its payload stable until that edge.
// Responses have no backpressure. Read beats are marked by resp_valid, and write completion by write_done.
interface burst_main_memory_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
);
  localparam int IDX_W = $clog2(BURST_LEN);

  logic                            req_valid;
  logic                            req_ready;
  logic                            req_write;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic [BURST_LEN*DATA_WIDTH-1:0] req_wline;
  logic                            resp_valid;
  logic [DATA_WIDTH-1:0]           resp_rdata;
  logic [IDX_W-1:0]                resp_idx;
  logic                            resp_last;
  logic                            write_done;

  modport master (
    output req_valid, req_write, req_addr, req_wline,
    input  req_ready, resp_valid, resp_rdata, resp_idx, resp_last, write_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wline,
    output req_ready, resp_valid, resp_rdata, resp_idx, resp_last, write_done
  );
endinterface

// File: rtl/burst_main_memory.sv
// Word-addressed RAM with programmable latency that serves one line (burst) read or write at a time.
// Define CRITICAL_WORD_FIRST_EN to start reads at the requested word and wrap within the line.
module burst_main_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 2**ADDR_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int LATENCY    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  burst_main_memory_if.slave   bus,
  output logic [1:0]           state_o
);
  localparam int OFF_W = $clog2(BURST_LEN);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic CWF_EN = 1'b1;
`else
  localparam logic CWF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [OFF_W-1:0]                beat_q;
  logic [OFF_W-1:0]                start_q;
  logic [ADDR_WIDTH-OFF_W-1:0]     line_q;
  logic                            write_q;
  logic [BURST_LEN*DATA_WIDTH-1:0] wline_q;
  logic                            req_ready_q;
  logic                            resp_valid_q;
  logic [DATA_WIDTH-1:0]           rdata_q;
  logic [OFF_W-1:0]                idx_q;
  logic                            resp_last_q;
  logic                            write_done_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [OFF_W-1:0]      rd_beat_d;
  logic [OFF_W-1:0]      rd_off_d;
  logic [DATA_WIDTH-1:0] rd_word_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_word_d;

  // Beat 0 is fetched on the WAIT->XFER edge, and each following beat is fetched on the edge that retires the previous one.
  assign rd_beat_d = (state_q == WAIT) ? '0 : beat_q + 1'b1;
  assign rd_off_d  = start_q + rd_beat_d;
  assign rd_word_d = mem[{line_q, rd_off_d}];

  assign mem_we_d  = (state_q == XFER) && write_q;
  assign wr_addr_d = {line_q, beat_q};
  assign wr_word_d = wline_q[beat_q*DATA_WIDTH +: DATA_WIDTH];

  // Storage has no reset, so a write cut short by reset keeps the words already written.
  always_ff @(posedge clk) begin
    if (mem_we_d) mem[wr_addr_d] <= wr_word_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      start_q      <= '0;
      line_q       <= '0;
      write_q      <= 1'b0;
      wline_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      idx_q        <= '0;
      resp_last_q  <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            line_q      <= bus.req_addr[ADDR_WIDTH-1:OFF_W];
            start_q     <= CWF_EN ? bus.req_addr[OFF_W-1:0] : '0;
            write_q     <= bus.req_write;
            wline_q     <= bus.req_wline;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            beat_q  <= '0;
            state_q <= XFER;
            if (!write_q) begin
              resp_valid_q <= 1'b1;
              rdata_q      <= rd_word_d;
              idx_q        <= rd_off_d;
              resp_last_q  <= (rd_beat_d == LAST_OFF);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        XFER: begin
          if (write_q) begin
            if (beat_q == LAST_OFF) begin
              write_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end else if (resp_last_q) begin
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end else begin
            beat_q      <= rd_beat_d;
            rdata_q     <= rd_word_d;
            idx_q       <= rd_off_d;
            resp_last_q <= (rd_beat_d == LAST_OFF);
          end
        end
        DONE: begin
          write_done_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_idx   = idx_q;
  assign bus.resp_last  = resp_last_q;
  assign bus.write_done = write_done_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_burst_main_memory.sv
// Directed bench for burst_main_memory: a default instance (L=3, B=4) and a small instance (L=1, B=2).
module tb_burst_main_memory;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int B  = 4;
  localparam int L  = 3;
  localparam int B2 = 2;
  localparam int L2 = 1;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  burst_main_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(B))  m ();
  burst_main_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(B2)) m2 ();
  logic [1:0] st, st2;

  burst_main_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024),
                      .BURST_LEN(B), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(m.slave), .state_o(st));

  burst_main_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024),
                      .BURST_LEN(B2), .LATENCY(L2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(m2.slave), .state_o(st2));

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] model_mem [1024];
  logic [DW+2:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller 1ns after the handshake edge (edge 0) with req_valid dropped.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [B*DW-1:0] wl);
    int waited;
    waited = 0;
    m.req_valid = 1'b1;
    m.req_write = wr;
    m.req_addr  = a;
    m.req_wline = wl;
    while (m.req_ready !== 1'b1 && waited < 64) begin
      step();
      waited++;
    end
    check("hs_ready", m.req_ready, 1'b1);
    step();
    m.req_valid = 1'b0;
  endtask

  task automatic expect_read(input logic [AW-1:0] a, input string tag);
    logic [1:0] start;
    logic [1:0] idx;
    logic [DW+2:0] e;
    start = CWF ? a[1:0] : 2'd0;
    for (int i = 0; i < B; i++) begin
      idx = start + 2'(i);
      exp_q.push_back({(i == B-1), idx, model_mem[{a[AW-1:2], idx}]});
    end
    for (int k = 1; k <= L + B; k++) begin
      step();
      check({tag, "_valid"}, m.resp_valid, (k >= L && k < L + B));
      check({tag, "_wdone"}, m.write_done, 1'b0);
      check({tag, "_ready"}, m.req_ready, (k == L + B));
      if (m.resp_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_beat"}, {m.resp_last, m.resp_idx, m.resp_rdata}, e);
      end
    end
    check({tag, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [B*DW-1:0] wl, input string tag);
    for (int k = 1; k <= L + B + 1; k++) begin
      step();
      check({tag, "_wdone"}, m.write_done, (k == L + B));
      check({tag, "_valid"}, m.resp_valid, 1'b0);
      check({tag, "_ready"}, m.req_ready, (k == L + B + 1));
    end
    for (int i = 0; i < B; i++) model_mem[{a[AW-1:2], 2'(i)}] = wl[i*DW +: DW];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] i2;
    m.req_valid = 1'b0; m.req_write = 1'b0; m.req_addr = '0; m.req_wline = '0;
    m2.req_valid = 1'b0; m2.req_write = 1'b0; m2.req_addr = '0; m2.req_wline = '0;

    #12;
    check("rst_ready", m.req_ready, 1'b1);
    check("rst_valid", m.resp_valid, 1'b0);
    check("rst_wdone", m.write_done, 1'b0);
    check("rst_state", st, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    issue(1'b1, 10'h010, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("wr_edge0_ready", m.req_ready, 1'b0);
    expect_write(10'h010, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, "wr10");

    issue(1'b0, 10'h012, '0);
    expect_read(10'h012, "rd12");

    // Second request (write of line 0x020) is held while the first read runs.
    issue(1'b0, 10'h010, '0);
    m.req_valid = 1'b1;
    m.req_write = 1'b1;
    m.req_addr  = 10'h020;
    m.req_wline = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    expect_read(10'h010, "busy_rd");
    step();
    m.req_valid = 1'b0;
    check("busy_accept_state", st, 2'd1);
    check("busy_accept_ready", m.req_ready, 1'b0);
    expect_write(10'h020, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, "busy_wr");
    issue(1'b0, 10'h021, '0);
    expect_read(10'h021, "rd21");

    // Reset after word 1 of a 0xBx line lands (edges 4 and 5).
    issue(1'b1, 10'h010, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    repeat (L + 2) step();
    #1 rst_n = 1'b0;
    #1;
    check("rst2_ready", m.req_ready, 1'b1);
    check("rst2_valid", m.resp_valid, 1'b0);
    check("rst2_wdone", m.write_done, 1'b0);
    check("rst2_state", st, 2'd0);
    model_mem[10'h010] = 32'hB0;
    model_mem[10'h011] = 32'hB1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue(1'b0, 10'h012, '0);
    expect_read(10'h012, "rd_after_rst");

    // Small instance: top line 0x3FE/0x3FF.
    m2.req_valid = 1'b1; m2.req_write = 1'b1; m2.req_addr = 10'h3FE;
    m2.req_wline = {32'hD1, 32'hD0};
    check("s_hs_ready", m2.req_ready, 1'b1);
    step();
    m2.req_valid = 1'b0;
    for (int k = 1; k <= L2 + B2 + 1; k++) begin
      step();
      check("s_wr_wdone", m2.write_done, (k == L2 + B2));
      check("s_wr_ready", m2.req_ready, (k == L2 + B2 + 1));
    end
    m2.req_valid = 1'b1; m2.req_write = 1'b0; m2.req_addr = 10'h3FF;
    check("s_rd_hs_ready", m2.req_ready, 1'b1);
    step();
    m2.req_valid = 1'b0;
    for (int k = 1; k <= L2 + B2; k++) begin
      step();
      check("s_rd_valid", m2.resp_valid, (k <= B2));
      check("s_rd_ready", m2.req_ready, (k == L2 + B2));
      if (k <= B2) begin
        i2 = (CWF ? 2'd1 : 2'd0) ^ 2'(k - 1);
        check("s_rd_idx", m2.resp_idx, i2[0]);
        check("s_rd_data", m2.resp_rdata, (i2[0] ? 32'hD1 : 32'hD0));
        check("s_rd_last", m2.resp_last, (k == B2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
